// File: rtl/ysyx_220053_pkg.sv
// Shared definitions for the ysyx_220053 load/store unit.
//   - access size encodings (SZ_*)
//   - byte-lane mask constants (MASK_*), unshifted, for lane offset 0
//   - LSU FSM state enum
package ysyx_220053_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// Combinational lane alignment for the LSU.
// Ports:
//   size, off        access size and byte offset within the 8-byte word
//   sdata            raw store data (rs2)
//   wdata, wmask     lane-replicated store data and byte-lane enables
//   uns, rdata       zero-extend select and raw 8-byte-aligned load data
//   ldata            extracted, sign/zero-extended load value
//   misaligned       access is not naturally aligned for its size
module ysyx_220053_lsu_align
  import ysyx_220053_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  off,
  input  logic [63:0] sdata,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  input  logic        uns,
  input  logic [63:0] rdata,
  output logic [63:0] ldata,
  output logic        misaligned
);

  logic [63:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    wdata      = sdata;
    wmask      = MASK_D;
    ldata      = shifted;
    misaligned = 1'b0;
    unique case (size)
      SZ_B: begin
        wdata = {8{sdata[7:0]}};
        wmask = MASK_B << off;
        ldata = uns ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wdata      = {4{sdata[15:0]}};
        wmask      = MASK_H << off;
        ldata      = uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        wdata      = {2{sdata[31:0]}};
        wmask      = MASK_W << off;
        ldata      = uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        misaligned = |off[1:0];
      end
      SZ_D: begin
        wdata      = sdata;
        wmask      = MASK_D;
        ldata      = shifted;
        misaligned = |off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: takes the ALU result as effective address (or writeback value for
// non-memory ops), performs at most one memory transaction, and presents the result to WB.
// Ports:
//   in_*   execute-side valid/ready handshake and instruction fields
//   mem_*  request/grant/response memory bus
//   wb_*   writeback-side valid/ready handshake and result fields
module ysyx_220053_lsu
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_result,
  input  logic [63:0]     in_wdata,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [63:0]     mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [63:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_we,
  output logic            wb_err
);

  lsu_state_e state_q, state_d;

  logic [63:0]     addr_q, sdata_q;
  logic            store_q, uns_q;
  logic [1:0]      size_q;
  logic [RD_W-1:0] rd_q;
  logic [63:0]     wb_data_q, wb_data_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_err_q, wb_err_d;

  logic        idle, accept, store_req;
  logic [1:0]  al_size;
  logic [2:0]  al_off;
  logic [63:0] al_wdata, al_ldata;
  logic [7:0]  al_wmask;
  logic        al_misaligned;

  assign idle     = (state_q == StIdle);
  assign accept   = in_valid & idle;
  assign in_ready = idle;

  // In IDLE the aligner judges the incoming op; afterwards it works on the latched one.
  assign al_size = idle ? in_size : size_q;
  assign al_off  = idle ? in_result[2:0] : addr_q[2:0];

  ysyx_220053_lsu_align u_align (
    .size       (al_size),
    .off        (al_off),
    .sdata      (sdata_q),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .uns        (uns_q),
    .rdata      (mem_rdata),
    .ldata      (al_ldata),
    .misaligned (al_misaligned)
  );

  // Memory-side outputs are zero outside REQ so reset and idle leave the bus quiet.
  assign mem_req   = (state_q == StReq);
  assign store_req = mem_req & store_q;
  assign mem_we    = store_req;
  assign mem_addr  = mem_req ? {addr_q[63:3], 3'b000} : 64'd0;
  assign mem_wdata = store_req ? al_wdata : 64'd0;
  assign mem_wmask = store_req ? al_wmask : 8'd0;

  assign wb_valid = (state_q == StDone);
  assign wb_data  = wb_data_q;
  assign wb_rd    = rd_q;
  assign wb_we    = wb_we_q;
  assign wb_err   = wb_err_q;

  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_err_d  = wb_err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          wb_data_d = 64'd0;
          wb_we_d   = 1'b0;
          wb_err_d  = 1'b0;
          if (!(in_load || in_store)) begin
            wb_data_d = in_result;
            wb_we_d   = 1'b1;
            state_d   = StDone;
          end else if (al_misaligned) begin
            wb_err_d = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_gnt) state_d = store_q ? StDone : StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          wb_data_d = al_ldata;
          wb_we_d   = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wb_data_q <= 64'd0;
      wb_we_q   <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      wb_err_q  <= wb_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 64'd0;
      sdata_q <= 64'd0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      rd_q    <= '0;
    end else if (accept) begin
      addr_q  <= in_result;
      sdata_q <= in_wdata;
      store_q <= in_store;
      uns_q   <= in_unsigned;
      size_q  <= in_size;
      rd_q    <= in_rd;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
module tb_ysyx_220053_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_result, in_wdata;
  logic        in_load, in_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, wb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_220053_lsu #(.RD_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_wdata   (in_wdata),
    .in_load    (in_load),
    .in_store   (in_store),
    .in_size    (in_size),
    .in_unsigned(in_unsigned),
    .in_rd      (in_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_err     (wb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; returns one cycle after the accepting edge.
  task automatic issue(input logic [63:0] res, input logic [63:0] wd, input logic ld,
                       input logic st, input logic [1:0] sz, input logic un,
                       input logic [4:0] rd);
    in_result = res; in_wdata = wd; in_load = ld; in_store = st;
    in_size = sz; in_unsigned = un; in_rd = rd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, mem_req, mem_we, wb_valid, wb_we, wb_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {in_ready, mem_req, mem_we, wb_valid, wb_we, wb_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wmask, wb_data, wb_rd} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h wmask=%h wb_data=%h wb_rd=%h expected all 0",
               mem_addr, mem_wdata, mem_wmask, wb_data, wb_rd);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nonmem();
    issue(64'h1234, 64'h0, 1'b0, 1'b0, 2'd3, 1'b0, 5'd9);
    checks++;
    if ({wb_valid, wb_we, wb_err, mem_req} !== 4'b1100) begin
      failures++;
      $display("FAIL nonmem_ctrl: got %b expected 1100", {wb_valid, wb_we, wb_err, mem_req});
    end
    checks++;
    if (wb_data !== 64'h1234 || wb_rd !== 5'd9) begin
      failures++;
      $display("FAIL nonmem_data: got %h rd %0d expected 1234 rd 9", wb_data, wb_rd);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL nonmem_return: in_ready=%b wb_valid=%b mem_req=%b expected 1 0 0",
               in_ready, wb_valid, mem_req);
    end
  endtask

  task automatic test_load(input string nm, input logic [63:0] addr, input logic [1:0] sz,
                           input logic un, input logic [63:0] rdata, input logic [63:0] exp);
    logic [63:0] exp_addr;
    exp_addr = {addr[63:3], 3'b000};
    mem_gnt = 1'b1;
    issue(addr, 64'h0, 1'b1, 1'b0, sz, un, 5'd3);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_req: req=%b we=%b addr=%h wb_valid=%b expected 1 0 %h 0",
               nm, mem_req, mem_we, mem_addr, wb_valid, exp_addr);
    end
    tick();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_wait: req=%b wb_valid=%b in_ready=%b expected 0 0 0",
               nm, mem_req, wb_valid, in_ready);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_err !== 1'b0 || wb_rd !== 5'd3) begin
      failures++;
      $display("FAIL %s_done: valid=%b we=%b err=%b rd=%0d expected 1 1 0 3",
               nm, wb_valid, wb_we, wb_err, wb_rd);
    end
    checks++;
    if (wb_data !== exp) begin
      failures++;
      $display("FAIL %s_data: got %h expected %h", nm, wb_data, exp);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: in_ready=%b wb_valid=%b expected 1 0", nm, in_ready, wb_valid);
    end
  endtask

  task automatic test_store(input string nm, input logic [63:0] addr, input logic [1:0] sz,
                            input logic [63:0] d, input logic [63:0] exp_wdata,
                            input logic [7:0] exp_mask);
    logic [63:0] exp_addr;
    exp_addr = {addr[63:3], 3'b000};
    mem_gnt = 1'b1;
    issue(addr, d, 1'b0, 1'b1, sz, 1'b0, 5'd4);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s_req: req=%b we=%b addr=%h expected 1 1 %h",
               nm, mem_req, mem_we, mem_addr, exp_addr);
    end
    checks++;
    if (mem_wdata !== exp_wdata || mem_wmask !== exp_mask) begin
      failures++;
      $display("FAIL %s_lanes: wdata=%h wmask=%h expected %h %h",
               nm, mem_wdata, mem_wmask, exp_wdata, exp_mask);
    end
    tick();
    mem_gnt = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_err !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: valid=%b we=%b err=%b req=%b expected 1 0 0 0",
               nm, wb_valid, wb_we, wb_err, mem_req);
    end
    tick();
  endtask

  task automatic test_misaligned(input string nm, input logic [63:0] addr, input logic [1:0] sz,
                                 input logic ld, input logic st);
    mem_gnt = 1'b1;
    issue(addr, 64'hFFFF, ld, st, sz, 1'b0, 5'd6);
    checks++;
    if ({wb_valid, wb_err, wb_we, mem_req} !== 4'b1100 || wb_data !== 64'h0) begin
      failures++;
      $display("FAIL %s: valid/err/we/req=%b data=%h expected 1100 0",
               nm, {wb_valid, wb_err, wb_we, mem_req}, wb_data);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_noreq: req=%b in_ready=%b expected 0 1", nm, mem_req, in_ready);
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_stall();
    // Request held three cycles without grant.
    mem_gnt = 1'b0;
    issue(64'h8000_0020, 64'h0000_0000_CAFE_F00D, 1'b0, 1'b1, 2'd2, 1'b0, 5'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h8000_0020 ||
          mem_wdata !== 64'hCAFE_F00D_CAFE_F00D || mem_wmask !== 8'h0F || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_req%0d: req=%b we=%b addr=%h wdata=%h wmask=%h in_ready=%b", i,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, in_ready);
      end
      if (i == 3) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      failures++;
      $display("FAIL stall_store_done: valid=%b we=%b expected 1 0", wb_valid, wb_we);
    end
    tick();
    // Writeback held off two cycles on a signed halfword load.
    wb_ready = 1'b0;
    mem_gnt  = 1'b1;
    issue(64'h8000_0004, 64'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd12);
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_F00D_0000_0000;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 64'hFFFF_FFFF_FFFF_F00D || wb_rd !== 5'd12 ||
          wb_we !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_wb%0d: valid=%b data=%h rd=%0d we=%b in_ready=%b", i,
                 wb_valid, wb_data, wb_rd, wb_we, in_ready);
      end
      if (i == 2) wb_ready = 1'b1;
      tick();
    end
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: in_ready=%b wb_valid=%b expected 1 0", in_ready, wb_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    mem_gnt = 1'b1;
    issue(64'h8000_0001, 64'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd2);
    tick();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstwait_in_wait: req=%b valid=%b in_ready=%b expected 0 0 0",
               mem_req, wb_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_req, wb_valid, wb_we, wb_err} !== 5'b10000 || wb_data !== 64'h0 ||
        mem_addr !== 64'h0 || mem_wmask !== 8'h0 || mem_wdata !== 64'h0) begin
      failures++;
      $display("FAIL rstwait_async: ctrl=%b data=%h addr=%h expected 10000 0 0",
               {in_ready, mem_req, wb_valid, wb_we, wb_err}, wb_data, mem_addr);
    end
    #2 rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0000_0000_FF00;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || wb_data !== 64'h0) begin
      failures++;
      $display("FAIL rstwait_ignore: valid=%b in_ready=%b data=%h expected 0 1 0",
               wb_valid, in_ready, wb_data);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_wdata = '0;
    in_load = 1'b0; in_store = 1'b0; in_size = 2'd0; in_unsigned = 1'b0; in_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b1;

    test_reset();
    test_nonmem();
    test_load("lb",  64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    test_load("lbu", 64'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h80);
    test_load("lw",  64'h8000_0004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    test_load("lwu", 64'h8000_0004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 64'h8765_4321);
    test_load("lhu", 64'h8000_0002, 2'd1, 1'b1, 64'h0000_0000_9ABC_0000, 64'h9ABC);
    test_load("ld",  64'h8000_0008, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    test_store("sh", 64'h8000_0006, 2'd1, 64'hABCD, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0);
    test_store("sb", 64'h8000_0005, 2'd0, 64'h5A, 64'h5A5A_5A5A_5A5A_5A5A, 8'h20);
    test_store("sw", 64'h8000_0004, 2'd2, 64'h1122_3344_5566_7788, 64'h5566_7788_5566_7788,
               8'hF0);
    test_store("sd", 64'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788,
               8'hFF);
    test_misaligned("mis_lw", 64'h8000_0002, 2'd2, 1'b1, 1'b0);
    test_misaligned("mis_sh", 64'h8000_0001, 2'd1, 1'b0, 1'b1);
    test_misaligned("mis_sd", 64'h8000_0004, 2'd3, 1'b0, 1'b1);
    test_stall();
    test_reset_in_wait();
    test_load("post_rst_lbu", 64'h8000_0001, 2'd0, 1'b1, 64'h0000_0000_0000_FF00, 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
